// File: rtl/conv_pkg.sv
// Shared definitions for the 5-tap convolution datapath (feeder and MAC).
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int TAPS   = 5;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [DATA_W-1:0] weight_t;

    typedef enum logic {
        FILL  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // Index width that stays at least one bit wide when only one entry exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_window_feeder_weight_bank.sv
// Filter weight register file: NUM_FILTERS x TAPS signed weights, one guarded
// write port and one registered 5-wide read port with same-cycle write forwarding.
module weight_bank
    import conv_pkg::*;
#(
    parameter int NUM_FILTERS = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we,
    input  logic [idx_w(NUM_FILTERS)-1:0]   wr_filt,
    input  logic [2:0]                      wr_tap,
    input  logic signed [DATA_W-1:0]        wr_data,
    input  logic [idx_w(NUM_FILTERS)-1:0]   rd_filt,
    output logic [TAPS*DATA_W-1:0]          rd_data
);

    weight_t bank [NUM_FILTERS][TAPS];
    logic    wr_ok;

    // Out-of-range taps or filters are dropped so they never alias onto real entries.
    always_comb begin
        wr_ok = we && (int'(wr_tap) < TAPS) && (int'(wr_filt) < NUM_FILTERS);
    end

    // Storage update plus registered read; a write to the entry being read is
    // forwarded so the new value shows on the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < NUM_FILTERS; f++) begin
                for (int t = 0; t < TAPS; t++) begin
                    bank[f][t] <= '0;
                end
            end
            rd_data <= '0;
        end else begin
            if (wr_ok) begin
                bank[wr_filt][wr_tap] <= wr_data;
            end
            for (int t = 0; t < TAPS; t++) begin
                if (wr_ok && (wr_filt == rd_filt) && (int'(wr_tap) == t)) begin
                    rd_data[t*DATA_W +: DATA_W] <= wr_data;
                end else begin
                    rd_data[t*DATA_W +: DATA_W] <= bank[rd_filt][t];
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Window/filter sequencer feeding the 5-tap MAC: collects samples into a
// sliding window, then presents that window with every filter, one per cycle.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int NUM_FILTERS = 8,
    parameter int FRAME_LEN   = 187
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [7:0]               s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic                            w_we,
    input  logic [idx_w(NUM_FILTERS)-1:0]   w_filt,
    input  logic [2:0]                      w_tap,
    input  logic signed [7:0]               w_data,
    output logic signed [7:0]               conv1,
    output logic signed [7:0]               conv2,
    output logic signed [7:0]               conv3,
    output logic signed [7:0]               conv4,
    output logic signed [7:0]               conv5,
    output logic signed [7:0]               weight1,
    output logic signed [7:0]               weight2,
    output logic signed [7:0]               weight3,
    output logic signed [7:0]               weight4,
    output logic signed [7:0]               weight5,
    output logic                            en,
    output logic [idx_w(NUM_FILTERS)-1:0]   filt_idx,
    output logic [$clog2(FRAME_LEN)-1:0]    win_idx,
    output logic                            busy,
    output logic                            frame_done
);

    localparam int FILT_W = idx_w(NUM_FILTERS);
    localparam int WIN_W  = $clog2(FRAME_LEN);
    localparam int CNT_W  = $clog2(FRAME_LEN + 1);
    localparam logic [FILT_W-1:0] LAST_FILT = FILT_W'(NUM_FILTERS - 1);

    state_t              state, state_nxt;
    logic [FILT_W-1:0]   filt_nxt;
    logic [CNT_W-1:0]    cnt, cnt_inc;
    logic                take, last_filt, frame_full, win_full;
    sample_t             win       [TAPS];
    sample_t             win_shift [TAPS];
    sample_t             conv_q    [TAPS];
    logic [TAPS*DATA_W-1:0] w_rd;

    assign cnt_inc    = cnt + CNT_W'(1);
    assign win_full   = (cnt_inc >= CNT_W'(TAPS));
    assign frame_full = (cnt == CNT_W'(FRAME_LEN));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next filter: FILL waits for a completing sample, SWEEP
    // walks the filters and hands back to FILL after the last one.
    always_comb begin
        state_nxt = state;
        filt_nxt  = '0;
        take      = 1'b0;
        last_filt = 1'b0;
        case (state)
            FILL: begin
                take = s_valid && s_ready;
                if (take && win_full) begin
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (filt_idx == LAST_FILT) begin
                    last_filt = 1'b1;
                    state_nxt = FILL;
                end else begin
                    filt_nxt = filt_idx + FILT_W'(1);
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Ready is decoded straight from the state, and held low during reset.
    always_comb begin
        s_ready = (state == FILL) && !rst;
    end

    // Window register after shifting in the current sample (newest at the top).
    always_comb begin
        for (int k = 0; k < TAPS - 1; k++) begin
            win_shift[k] = win[k+1];
        end
        win_shift[TAPS-1] = s_data;
    end

    // Sequencing registers: sample count, window index and MAC strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            win_idx    <= '0;
            filt_idx   <= '0;
            en         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            filt_idx   <= filt_nxt;
            en         <= (state_nxt == SWEEP);
            busy       <= (state_nxt == SWEEP);
            frame_done <= last_filt && frame_full;
            if (take) begin
                cnt <= cnt_inc;
            end else if (last_filt && frame_full) begin
                cnt <= '0;
            end
            if (last_filt) begin
                win_idx <= frame_full ? '0 : win_idx + WIN_W'(1);
            end
        end
    end

    // Window shift on every accepted sample; the MAC-facing copy only updates
    // when a complete window is formed, so it holds steady between sweeps.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                win[k]    <= '0;
                conv_q[k] <= '0;
            end
        end else if (take) begin
            for (int k = 0; k < TAPS; k++) begin
                win[k] <= win_shift[k];
            end
            if (win_full) begin
                for (int k = 0; k < TAPS; k++) begin
                    conv_q[k] <= win_shift[k];
                end
            end
        end
    end

    // Reads the filter that will be presented next cycle (filter 0 outside SWEEP).
    weight_bank #(
        .NUM_FILTERS(NUM_FILTERS)
    ) u_weight_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (w_we && !busy),
        .wr_filt (w_filt),
        .wr_tap  (w_tap),
        .wr_data (w_data),
        .rd_filt (filt_nxt),
        .rd_data (w_rd)
    );

    assign conv1   = conv_q[0];
    assign conv2   = conv_q[1];
    assign conv3   = conv_q[2];
    assign conv4   = conv_q[3];
    assign conv5   = conv_q[4];
    assign weight1 = w_rd[0*DATA_W +: DATA_W];
    assign weight2 = w_rd[1*DATA_W +: DATA_W];
    assign weight3 = w_rd[2*DATA_W +: DATA_W];
    assign weight4 = w_rd[3*DATA_W +: DATA_W];
    assign weight5 = w_rd[4*DATA_W +: DATA_W];

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: directed vector table, hand-written reset
// sequence, and randomized traffic against a transaction-level model.
module tb_conv_window_feeder;

    localparam int NF = 2;
    localparam int FL = 6;

    logic              clk;
    logic              rst;
    logic signed [7:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              w_we;
    logic [0:0]        w_filt;
    logic [2:0]        w_tap;
    logic signed [7:0] w_data;
    logic signed [7:0] conv1, conv2, conv3, conv4, conv5;
    logic signed [7:0] weight1, weight2, weight3, weight4, weight5;
    logic              en;
    logic [0:0]        filt_idx;
    logic [2:0]        win_idx;
    logic              busy;
    logic              frame_done;

    conv_window_feeder #(.NUM_FILTERS(NF), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .w_we(w_we), .w_filt(w_filt), .w_tap(w_tap), .w_data(w_data),
        .conv1(conv1), .conv2(conv2), .conv3(conv3), .conv4(conv4), .conv5(conv5),
        .weight1(weight1), .weight2(weight2), .weight3(weight3), .weight4(weight4), .weight5(weight5),
        .en(en), .filt_idx(filt_idx), .win_idx(win_idx), .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [39:0] dut_conv, dut_wt;
    assign dut_conv = {conv1, conv2, conv3, conv4, conv5};
    assign dut_wt   = {weight1, weight2, weight3, weight4, weight5};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [39:0] pk5(input int a, input int b, input int c, input int d, input int e);
        logic [7:0] x0, x1, x2, x3, x4;
        x0 = a[7:0]; x1 = b[7:0]; x2 = c[7:0]; x3 = d[7:0]; x4 = e[7:0];
        return {x0, x1, x2, x3, x4};
    endfunction

    // ---------------- reference model (window/filter transactions) ----------------
    typedef struct {
        logic [39:0] conv;
        logic [39:0] wt;
        int          filt;
        int          win;
        bit          last;
    } ev_t;

    ev_t         ev_q[$];
    logic [7:0]  frame_q[$];
    logic [7:0]  wmem [NF][5];
    logic [39:0] last_conv = '0;
    bit          fd_exp = 1'b0;
    bit          mon_on = 1'b0;

    logic [39:0] m_cv, m_wt, m_win_v;
    int          m_f, m_w, m_n;
    bit          m_en, m_rdy, m_fdn;
    ev_t         m_e;

    function automatic logic [39:0] wpack(input int f);
        return {wmem[f][0], wmem[f][1], wmem[f][2], wmem[f][3], wmem[f][4]};
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            m_en = (ev_q.size() > 0);
            if (m_en) begin
                m_cv = ev_q[0].conv; m_wt = ev_q[0].wt; m_f = ev_q[0].filt; m_w = ev_q[0].win;
            end else begin
                m_cv = last_conv; m_wt = wpack(0); m_f = 0;
                m_w  = (frame_q.size() >= 5) ? frame_q.size() - 4 : 0;
            end
            chk("m_ready", s_ready, !rst && !m_en);
            chk("m_en", en, m_en);
            chk("m_busy", busy, m_en);
            chk("m_conv", dut_conv, m_cv);
            chk("m_weight", dut_wt, m_wt);
            chk("m_filt", filt_idx, m_f);
            chk("m_win", win_idx, m_w);
            chk("m_fdone", frame_done, fd_exp);

            if (rst) begin
                ev_q.delete();
                frame_q.delete();
                for (int f = 0; f < NF; f++) for (int t = 0; t < 5; t++) wmem[f][t] = '0;
                last_conv = '0;
                fd_exp    = 1'b0;
            end else begin
                m_rdy = (ev_q.size() == 0);
                m_fdn = 1'b0;
                if (!m_rdy) begin
                    m_e   = ev_q.pop_front();
                    m_fdn = m_e.last;
                end
                if (w_we && m_rdy && (w_tap < 3'd5) && (int'(w_filt) < NF))
                    wmem[w_filt][w_tap] = w_data;
                if (s_valid && m_rdy) begin
                    frame_q.push_back(s_data);
                    m_n = frame_q.size();
                    if (m_n >= 5) begin
                        m_win_v = {frame_q[m_n-5], frame_q[m_n-4], frame_q[m_n-3], frame_q[m_n-2], frame_q[m_n-1]};
                        for (int f = 0; f < NF; f++) begin
                            m_e.conv = m_win_v;
                            m_e.wt   = wpack(f);
                            m_e.filt = f;
                            m_e.win  = m_n - 5;
                            m_e.last = (m_n == FL) && (f == NF - 1);
                            ev_q.push_back(m_e);
                        end
                        last_conv = m_win_v;
                        if (m_n == FL) frame_q.delete();
                    end
                end
                fd_exp = m_fdn;
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          sv;
        logic [7:0]  sd;
        bit          we;
        logic [0:0]  fi;
        logic [2:0]  tp;
        logic [7:0]  wd;
        bit          x_en;
        int          x_filt;
        int          x_win;
        bit          x_rdy;
        bit          x_fd;
        logic [39:0] x_cv;
        logic [39:0] x_wt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit sv, input int sd, input bit we, input int fi, input int tp, input int wd,
                       input bit xe, input int xf, input int xw, input bit xr, input bit xfd,
                       input logic [39:0] xc, input logic [39:0] xwt);
        vec_t v;
        v.sv = sv; v.sd = sd[7:0]; v.we = we; v.fi = fi[0:0]; v.tp = tp[2:0]; v.wd = wd[7:0];
        v.x_en = xe; v.x_filt = xf; v.x_win = xw; v.x_rdy = xr; v.x_fd = xfd; v.x_cv = xc; v.x_wt = xwt;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [39:0] Z, W0, M1, C1, C2, C3;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; w_we = 1'b0; w_filt = '0; w_tap = '0; w_data = '0;
        for (int f = 0; f < NF; f++) for (int t = 0; t < 5; t++) wmem[f][t] = '0;

        step();
        mon_on = 1'b1;
        chk("rst_ready", s_ready, 0);
        chk("rst_en", en, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_ready", s_ready, 1);
        chk("post_rst_conv", dut_conv, 0);
        chk("post_rst_wt", dut_wt, 0);
        chk("post_rst_ctl", {en, busy, frame_done, filt_idx, win_idx}, 0);
        repeat (4) step();

        Z  = '0;
        W0 = pk5(1, 2, 3, 4, 5);
        M1 = pk5(-1, -1, -1, -1, -1);
        C1 = pk5(10, 20, 30, 40, 50);
        C2 = pk5(20, 30, 40, 50, 60);
        C3 = pk5(-128, 127, 1, 2, 3);

        //  sv sd    we fi tp wd    en f  w  rdy fd conv wt
        add(0, 0,    1, 0, 0, 1,    0, 0, 0, 1, 0, Z,  pk5(1, 0, 0, 0, 0));
        add(0, 0,    1, 0, 1, 2,    0, 0, 0, 1, 0, Z,  pk5(1, 2, 0, 0, 0));
        add(0, 0,    1, 0, 2, 3,    0, 0, 0, 1, 0, Z,  pk5(1, 2, 3, 0, 0));
        add(0, 0,    1, 0, 3, 4,    0, 0, 0, 1, 0, Z,  pk5(1, 2, 3, 4, 0));
        add(0, 0,    1, 0, 4, 5,    0, 0, 0, 1, 0, Z,  W0);
        for (int t = 0; t < 5; t++)
            add(0, 0, 1, 1, t, -1,  0, 0, 0, 1, 0, Z,  W0);
        add(0, 0,    1, 0, 5, 77,   0, 0, 0, 1, 0, Z,  W0);
        add(1, 10,   0, 0, 0, 0,    0, 0, 0, 1, 0, Z,  W0);
        add(1, 20,   0, 0, 0, 0,    0, 0, 0, 1, 0, Z,  W0);
        add(1, 30,   0, 0, 0, 0,    0, 0, 0, 1, 0, Z,  W0);
        add(1, 40,   0, 0, 0, 0,    0, 0, 0, 1, 0, Z,  W0);
        add(1, 50,   0, 0, 0, 0,    1, 0, 0, 0, 0, C1, W0);
        add(0, 0,    1, 0, 0, 99,   1, 1, 0, 0, 0, C1, M1);
        add(0, 0,    0, 0, 0, 0,    0, 0, 1, 1, 0, C1, W0);
        add(1, 60,   0, 0, 0, 0,    1, 0, 1, 0, 0, C2, W0);
        add(0, 0,    0, 0, 0, 0,    1, 1, 1, 0, 0, C2, M1);
        add(0, 0,    0, 0, 0, 0,    0, 0, 0, 1, 1, C2, W0);
        add(0, 0,    0, 0, 0, 0,    0, 0, 0, 1, 0, C2, W0);
        add(1, -128, 0, 0, 0, 0,    0, 0, 0, 1, 0, C2, W0);
        add(1, 127,  0, 0, 0, 0,    0, 0, 0, 1, 0, C2, W0);
        add(1, 1,    0, 0, 0, 0,    0, 0, 0, 1, 0, C2, W0);
        add(1, 2,    0, 0, 0, 0,    0, 0, 0, 1, 0, C2, W0);
        add(1, 3,    0, 0, 0, 0,    1, 0, 0, 0, 0, C3, W0);
        add(0, 0,    0, 0, 0, 0,    1, 1, 0, 0, 0, C3, M1);
        add(0, 0,    0, 0, 0, 0,    0, 0, 1, 1, 0, C3, W0);

        foreach (tbl[i]) begin
            s_valid = tbl[i].sv; s_data = tbl[i].sd;
            w_we = tbl[i].we; w_filt = tbl[i].fi; w_tap = tbl[i].tp; w_data = tbl[i].wd;
            step();
            chk($sformatf("v%0d_en", i), en, tbl[i].x_en);
            chk($sformatf("v%0d_filt", i), filt_idx, tbl[i].x_filt);
            chk($sformatf("v%0d_win", i), win_idx, tbl[i].x_win);
            chk($sformatf("v%0d_ready", i), s_ready, tbl[i].x_rdy);
            chk($sformatf("v%0d_fdone", i), frame_done, tbl[i].x_fd);
            chk($sformatf("v%0d_conv", i), dut_conv, tbl[i].x_cv);
            chk($sformatf("v%0d_wt", i), dut_wt, tbl[i].x_wt);
        end
        s_valid = 1'b0; w_we = 1'b0;

        // Reset landing on the first SWEEP cycle.
        s_valid = 1'b1; s_data = 8'sd9;
        step();
        chk("rs_en_pre", en, 1);
        chk("rs_conv5_pre", conv5, 9);
        rst = 1'b1; s_valid = 1'b0;
        step();
        chk("rs_en", en, 0);
        chk("rs_fdone", frame_done, 0);
        chk("rs_wt", dut_wt, 0);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            s_valid = 1'b1; s_data = 8'(k);
            step();
            chk($sformatf("rs_noen%0d", k), en, 0);
        end
        s_data = 8'sd5;
        step();
        chk("rs_en_new", en, 1);
        chk("rs_win_new", win_idx, 0);
        chk("rs_conv_new", dut_conv, pk5(1, 2, 3, 4, 5));
        s_valid = 1'b0;
        repeat (2) step();

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 399) == 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            w_we    = ($urandom_range(0, 5) == 0);
            w_filt  = 1'($urandom);
            w_tap   = 3'($urandom_range(0, 7));
            w_data  = 8'($urandom);
            step();
        end
        rst = 1'b0; s_valid = 1'b0; w_we = 1'b0;
        repeat (4) step();
        mon_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
